dot_product_acc: RTL and testbench

Unsigned 8-bit dot-product engine built around the `wallace_tree` 8x8 multiplier. Registers each accepted operand pair, multiplies it in `wallace_tree`, registers the 16-bit product, and accumulates a programmable number of terms. Presents the final sum on a valid/ready output. Sits directly downstream of the operand source and consumes every `wallace_tree` product.

---
 rtl/dot_product_acc_if.sv | 27 ++
 rtl/dot_product_acc.sv | 131 +++++++++++++
 tb/tb_dot_product_acc.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_acc_if.sv
// Operand/result bus of dot_product_acc: job start, operand valid/ready, result valid/ready.
interface dot_product_acc_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/dot_product_acc.sv
// Unsigned 8-bit dot-product engine: operand reg -> wallace_tree -> product reg -> accumulator.
// Optional macro DPA_SAT_EN: saturate the accumulator on carry-out instead of wrapping.

module wallace_tree (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] product_o
);
  logic [7:0][15:0] pp;
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = b_i[i] ? (16'(a_i) << i) : 16'd0;
  end

  // 3:2 carry-save compressor; upper carries drop since the true product fits in 16 bits
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
  assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
  assign {c2, s2} = csa(s0, c0, s1);
  assign {c3, s3} = csa(c1, pp[6], pp[7]);
  assign {c4, s4} = csa(s2, c2, s3);
  assign {c5, s5} = csa(s4, c4, c3);
  assign product_o = s5 + c5;
endmodule

module dot_product_acc #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  dot_product_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       vld_pipe_q;  // [0]=operand stage P1, [1]=product stage P2
  logic [7:0]       op_a_q, op_b_q;
  logic [15:0]      prod_q, prod;
  logic [ACC_W:0]   sum;
  logic             in_ready, hs;

  wallace_tree u_mul (.a_i(op_a_q), .b_i(op_b_q), .product_o(prod));

  assign in_ready = (state_q == RUN) && (cnt_q < len_q);
  assign hs       = bus.in_valid & in_ready;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign sum      = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (vld_pipe_q[1]) begin
      if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef DPA_SAT_EN
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end
    unique case (state_q)
      IDLE: if (bus.start) begin
        acc_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
        if (bus.len != '0) begin
          len_d   = bus.len;
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: if (hs) begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) state_d = DRAIN;
      end
      // An empty P1 means the last product is in P2 and lands in acc this edge
      DRAIN: if (!vld_pipe_q[0]) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      vld_pipe_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      prod_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      vld_pipe_q <= {vld_pipe_q[0], hs};
      if (hs) begin
        op_a_q <= bus.a;
        op_b_q <= bus.b;
      end
      if (vld_pipe_q[0]) prod_q <= prod;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dot_product_acc.sv
// Randomized self-checking bench for dot_product_acc (default widths plus an ACC_W=16 instance).
module tb_dot_product_acc;
`ifdef DPA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  byte unsigned qa[$];
  byte unsigned qb[$];
  bit vpat[$];

  always #5 clk = ~clk;

  dot_product_acc_if #(.ACC_W(24), .LEN_W(8)) bus ();
  dot_product_acc_if #(.ACC_W(16), .LEN_W(8)) bus16 ();

  dot_product_acc #(.ACC_W(24), .LEN_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
  dot_product_acc #(.ACC_W(16), .LEN_W(8)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(bus16.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain sum of products, then wrap or clamp at 2^w
  function automatic longint model_res(input longint total, input int w);
    longint lim = longint'(1) << w;
    if (total < lim) return total;
    return SAT ? lim - 1 : total % lim;
  endfunction

  function automatic bit model_ovf(input longint total, input int w);
    return total >= (longint'(1) << w);
  endfunction

  function automatic longint total_of(input int n);
    longint t = 0;
    for (int i = 0; i < n; i++) t += longint'(qa[i]) * longint'(qb[i]);
    return t;
  endfunction

  // Runs one job on the 24-bit instance and records what it observed; callers compare.
  // mode: 0 back-to-back, 1 random gaps, 2 valid pattern from vpat
  task automatic run24(input int n, input int mode, input bit noise, input bit extra,
                       output logic [23:0] acc, output logic ovf, output int t_valid,
                       output int lat, output int hs, output logic rdy_after,
                       output logic busy_after);
    int idx = 0;
    int cyc;
    int last = -1;
    bit v;
    acc = 'x; ovf = 1'bx; t_valid = -1; lat = -1; hs = 0; rdy_after = 1'bx;
    bus.start = 1'b1; bus.len = n[7:0]; bus.in_valid = 1'b0;
    step();
    cyc = 1;
    bus.start = 1'b0;
    while (cyc < 1500) begin
      if (last >= 0 && cyc == last + 1) rdy_after = bus.in_ready;
      if (bus.out_valid) begin
        t_valid = cyc;
        break;
      end
      if (idx < n) begin
        case (mode)
          0: v = 1'b1;
          1: v = ($urandom_range(0, 3) != 0);
          default: v = (vpat.size() != 0) ? vpat.pop_front() : 1'b1;
        endcase
        bus.in_valid = v; bus.a = qa[idx]; bus.b = qb[idx];
      end else begin
        bus.in_valid = extra ? 1'b1 : (noise && ($urandom_range(0, 1) == 1));
        bus.a = 8'($urandom); bus.b = 8'($urandom);
      end
      if (noise) begin
        bus.start = ($urandom_range(0, 1) == 1);
        bus.len = 8'($urandom);
      end
      if (bus.in_valid && bus.in_ready) begin
        hs++;
        if (idx < n) begin
          idx++;
          last = cyc;
        end
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0; bus.start = 1'b0;
    if (t_valid >= 0) begin
      acc = bus.out_acc; ovf = bus.out_ovf;
      lat = (last >= 0) ? t_valid - last : t_valid;
    end
    bus.out_ready = 1'b1; bus.start = noise; bus.len = 8'd5;
    step();
    busy_after = bus.busy;
    bus.out_ready = 1'b0; bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy});
    end
    checks++;
    if (bus.out_acc !== 24'd0) begin
      failures++; $display("FAIL reset_acc got=%0d exp=0", bus.out_acc);
    end
    checks++;
    if ({bus16.out_valid, bus16.busy, bus16.out_acc} !== 18'd0) begin
      failures++; $display("FAIL reset16 got=%0h exp=0", {bus16.out_valid, bus16.busy, bus16.out_acc});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [23:0] acc; logic ovf, ra, ba; int tv, lat, hs;
    qa = '{3, 10, 255, 0}; qb = '{5, 10, 255, 77};
    run24(4, 0, 1'b0, 1'b0, acc, ovf, tv, lat, hs, ra, ba);
    checks++;
    if (acc !== 24'd65140) begin failures++; $display("FAIL basic_acc got=%0d exp=65140", acc); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++;
    if (tv != 7) begin failures++; $display("FAIL basic_start_to_valid got=%0d exp=7", tv); end
    checks++;
    if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_gaps();
    logic [23:0] acc; logic ovf, ra, ba; int tv, lat, hs;
    qa = '{2, 7, 1}; qb = '{2, 9, 1};
    vpat = '{1, 0, 0, 1, 0, 1};
    run24(3, 2, 1'b0, 1'b1, acc, ovf, tv, lat, hs, ra, ba);
    checks++;
    if (acc !== 24'd68) begin failures++; $display("FAIL gaps_acc got=%0d exp=68", acc); end
    checks++;
    if (ra !== 1'b0) begin failures++; $display("FAIL gaps_ready_drop got=%b exp=0", ra); end
    checks++;
    if (hs != 3) begin failures++; $display("FAIL gaps_handshakes got=%0d exp=3", hs); end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL gaps_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_len0_hold();
    bus.start = 1'b1; bus.len = 8'd0;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd0) begin
      failures++; $display("FAIL len0_result got=%b/%0d exp=1/0", bus.out_valid, bus.out_acc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd0 || bus.out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL len0_hold cyc=%0d got=%b/%0d/%b exp=1/0/0", i, bus.out_valid, bus.out_acc, bus.out_ovf);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL len0_release got busy=%b valid=%b exp=0/0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_sat16();
    longint tot = 2 * 65025;
    bus16.start = 1'b1; bus16.len = 8'd2;
    step();
    bus16.start = 1'b0; bus16.in_valid = 1'b1; bus16.a = 8'd255; bus16.b = 8'd255;
    step(); step();
    bus16.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus16.out_valid; i++) step();
    checks++;
    if (bus16.out_valid !== 1'b1) begin
      failures++; $display("FAIL sat16_timeout got=%b exp=1", bus16.out_valid);
    end
    checks++;
    if (bus16.out_acc !== 16'(model_res(tot, 16))) begin
      failures++; $display("FAIL sat16_acc got=%0d exp=%0d", bus16.out_acc, model_res(tot, 16));
    end
    checks++;
    if (bus16.out_ovf !== model_ovf(tot, 16)) begin
      failures++; $display("FAIL sat16_ovf got=%b exp=%b", bus16.out_ovf, model_ovf(tot, 16));
    end
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [23:0] acc; logic ovf, ra, ba; int tv, lat, hs, n;
    longint tot;
    for (int j = 0; j < 200; j++) begin
      n = $urandom_range(1, 255);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(8'($urandom)); qb.push_back(8'($urandom));
      end
      tot = total_of(n);
      run24(n, 1, 1'b1, 1'b0, acc, ovf, tv, lat, hs, ra, ba);
      checks++;
      if (acc !== 24'(model_res(tot, 24)) || ovf !== model_ovf(tot, 24)) begin
        failures++;
        $display("FAIL random_job%0d len=%0d got=%0d/%b exp=%0d/%b", j, n, acc, ovf,
                 model_res(tot, 24), model_ovf(tot, 24));
      end
      checks++;
      if (lat != 3 || hs != n || ba !== 1'b0) begin
        failures++;
        $display("FAIL random_ctrl%0d got lat=%0d hs=%0d busy=%b exp 3/%0d/0", j, lat, hs, ba, n);
      end
    end
  endtask

  task automatic test_reset_drain();
    logic [23:0] acc; logic ovf, ra, ba; int tv, lat, hs;
    bus.start = 1'b1; bus.len = 8'd2;
    step();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a = 8'd200; bus.b = 8'd100;
    step();
    bus.a = 8'd50;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL drain_state got busy=%b rdy=%b exp=1/0", bus.busy, bus.in_ready);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, bus.out_acc} !== 28'd0) begin
      failures++;
      $display("FAIL drain_reset got=%0h exp=0", {bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, bus.out_acc});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL drain_discard cyc=%0d got=%b/%b exp=0/0", i, bus.out_valid, bus.busy);
      end
    end
    qa = '{12}; qb = '{12};
    run24(1, 0, 1'b0, 1'b0, acc, ovf, tv, lat, hs, ra, ba);
    checks++;
    if (acc !== 24'd144 || ovf !== 1'b0) begin
      failures++; $display("FAIL post_reset_job got=%0d/%b exp=144/0", acc, ovf);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    bus16.start = 1'b0; bus16.len = '0; bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
    bus16.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_len0_hold();
    test_sat16();
    test_random();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
